sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_ctrl.sv | 145 ++++++++++++++
 tb/tb_sar_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample/hold sequencing, MSB-first
// binary search on the DAC code, and a registered result with a done pulse.
module sar_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned SAMPLE_CYC = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         comp_in,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned MAX_CYC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] TOP_IDX     = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        TRIAL,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   trial_q, trial_d;
    logic [N-1:0]   result_q, result_d;
    logic [N-1:0]   decided;
    logic           sample_q, sample_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   dac_q, dac_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dac_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dac_q    <= dac_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        decided  = trial_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                    trial_d = '0;
                    idx_d   = TOP_IDX;
                end
            end
            SAMPLE: begin
                trial_d = '0;
                idx_d   = TOP_IDX;
                if (cnt_q == SAMPLE_LAST) begin
                    state_d          = TRIAL;
                    cnt_d            = '0;
                    trial_d[TOP_IDX] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TRIAL: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Comparator is read only at the end of the settle window
                    decided[idx_q] = comp_in;
                    cnt_d          = '0;
                    trial_d        = decided;
                    if (idx_q == '0) begin
                        result_d = decided;
                        state_d  = DONE;
                    end else begin
                        idx_d                  = idx_q - IW'(1);
                        trial_d[idx_q - IW'(1)] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                    trial_d = '0;
                    idx_d   = TOP_IDX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sample_d = (state_d == SAMPLE);
        busy_d   = (state_d == SAMPLE) || (state_d == TRIAL);
        done_d   = (state_d == DONE);
        case (state_d)
            TRIAL:   dac_d = trial_d;
            DONE:    dac_d = result_d;
            default: dac_d = '0;
        endcase
    end

    assign sample   = sample_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dac_code = dac_q;
    assign result   = result_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: ideal comparator model, rail codes, back-to-back,
// mid-conversion reset, and a small-parameter instance.
`timescale 1ns/1ps
module tb_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       comp;
    logic       sample;
    logic [7:0] dac;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] vin;
    int         mode;

    logic       s_start;
    logic       s_comp;
    logic       s_sample;
    logic [3:0] s_dac;
    logic       s_busy;
    logic       s_done;
    logic [3:0] s_result;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] dac_tr [40];

    always #5 clk = ~clk;

    // mode 0: ideal comparator, 1: stuck low, 2: stuck high
    assign comp   = (mode == 0) ? (vin >= dac) : (mode == 2);
    assign s_comp = (4'h9 >= s_dac);

    sar_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .comp_in  (comp),
        .sample   (sample),
        .dac_code (dac),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    sar_ctrl #(.N(4), .SAMPLE_CYC(1), .SETTLE_CYC(3)) u_small (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .comp_in  (s_comp),
        .sample   (s_sample),
        .dac_code (s_dac),
        .busy     (s_busy),
        .done     (s_done),
        .result   (s_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion from a single start pulse; k=0 is the cycle after the start edge
    task automatic conv(input logic [7:0] v, input int m, input logic [7:0] exp_res,
                        input logic [7:0] prev_res);
        int busy_n;
        int samp_n;
        int done_k;
        vin    = v;
        mode   = m;
        start  = 1'b1;
        step();
        start  = 1'b0;
        busy_n = 0;
        samp_n = 0;
        done_k = -1;
        for (int k = 0; k < 40; k++) begin
            dac_tr[k] = dac;
            if (busy) busy_n++;
            if (sample) samp_n++;
            if (done) begin
                done_k = k;
                break;
            end
            check("result_stable", 32'(result), 32'(prev_res));
            step();
        end
        check("latency", 32'(done_k), 32'd20);
        check("result", 32'(result), 32'(exp_res));
        check("dac_in_done", 32'(dac), 32'(exp_res));
        check("busy_cycles", 32'(busy_n), 32'd20);
        check("sample_cycles", 32'(samp_n), 32'd4);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_tr [8];
        int  n_done;
        logic prev_done;
        int  busy_n;
        int  samp_n;
        int  done_k;

        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin     = 8'h00;
        mode    = 0;
        rst     = 1'b1;
        start   = 1'b1;
        s_start = 1'b0;

        // reset wins over start
        step();
        step();
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dac", 32'(dac), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) step();
        check("idle_wait_busy", 32'(busy), 32'd0);

        // ideal comparator, vin = 0xA5
        conv(8'hA5, 0, 8'hA5, 8'h00);
        check("sample_phase_dac", 32'(dac_tr[0]), 32'd0);
        for (int j = 0; j < 8; j++) begin
            check("trial_code_a", 32'(dac_tr[4 + 2*j]), 32'(exp_tr[j]));
            check("trial_code_b", 32'(dac_tr[5 + 2*j]), 32'(exp_tr[j]));
        end

        // rail codes
        conv(8'h00, 1, 8'h00, 8'hA5);
        conv(8'hFF, 2, 8'hFF, 8'h00);

        // start held high (toggling while busy): back-to-back conversions
        vin       = 8'hA5;
        mode      = 0;
        start     = 1'b1;
        step();
        n_done    = 0;
        prev_done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (prev_done) check("b2b_sample_after_done", 32'(sample), 32'd1);
            if (done) begin
                n_done++;
                check("b2b_done_phase", 32'(k % 21), 32'd20);
                check("b2b_result", 32'(result), 32'hA5);
            end
            prev_done = done;
            start = done ? 1'b1 : ((k % 2) == 1);
            step();
        end
        check("b2b_done_count", 32'(n_done), 32'd3);
        start = 1'b0;
        repeat (25) step();
        check("b2b_idle", 32'(busy), 32'd0);

        // reset at the 10th edge after start aborts the conversion
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        check("abort_sample", 32'(sample), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dac", 32'(dac), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        rst    = 1'b0;
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done || busy) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        conv(8'h3C, 0, 8'h3C, 8'h00);

        // N=4, SAMPLE_CYC=1, SETTLE_CYC=3, vin=0x9
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        busy_n  = 0;
        samp_n  = 0;
        done_k  = -1;
        for (int k = 0; k < 30; k++) begin
            if (s_busy) busy_n++;
            if (s_sample) samp_n++;
            if (s_done) begin
                done_k = k;
                break;
            end
            step();
        end
        check("small_latency", 32'(done_k), 32'd13);
        check("small_result", 32'(s_result), 32'h9);
        check("small_busy", 32'(busy_n), 32'd13);
        check("small_sample", 32'(samp_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
